// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - packs symbolic MIPS instructions into 32-bit words and loads them into instruction memory
//
// Ports:
//   clk, rst          rising-edge clock; synchronous active-low reset
//   start             one-cycle pulse that restarts a load session
//   in_valid/in_ready instruction handshake; in_last marks the final instruction
//   op_sel, rs, rt, rd, imm  symbolic instruction fields
//   imem_we/imem_addr/imem_wdata  registered instruction memory write port
//   count             words written this session
//   err               sticky flag: an invalid op_sel was accepted
//   full              memory capacity reached
//   prog_done         program load complete
//
// Optional feature: define HALT_APPEND_EN to append a halt word (32'hFC00_0000)
// after the final instruction.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              full,
  output logic              prog_done
);

`ifdef HALT_APPEND_EN
  typedef enum logic [1:0] {S_LOAD = 2'd0, S_APPEND = 2'd1, S_DONE = 2'd2, S_FULL = 2'd3} state_t;
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
`else
  typedef enum logic [1:0] {S_LOAD = 2'd0, S_DONE = 2'd2, S_FULL = 2'd3} state_t;
`endif

  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_LAST  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic              enc_valid;
  logic              xfer;
  logic              last_slot;

  always_comb begin
    enc_valid = 1'b1;
    word      = 32'h0;
    case (op_sel)
      4'd0: word = {6'h00, rs, rt, rd, 5'b0, 6'h20};
      4'd1: word = {6'h00, rs, rt, rd, 5'b0, 6'h22};
      4'd2: word = {6'h00, rs, rt, rd, 5'b0, 6'h24};
      4'd3: word = {6'h00, rs, rt, rd, 5'b0, 6'h25};
      4'd4: word = {6'h00, rs, rt, rd, 5'b0, 6'h2A};
      4'd5: word = {6'h08, rs, rt, imm};
      4'd6: word = {6'h23, rs, rt, imm};
      4'd7: word = {6'h2B, rs, rt, imm};
      4'd8: word = {6'h04, rs, rt, imm};
      default: enc_valid = 1'b0;
    endcase
  end

  assign in_ready  = (state == S_LOAD) && !full;
  assign xfer      = in_valid && in_ready;
  // This transfer writes the final free word of memory.
  assign last_slot = enc_valid && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_LOAD;
      ptr        <= BASE_ADDR;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      err        <= 1'b0;
      full       <= 1'b0;
      prog_done  <= 1'b0;
    end else if (start) begin
      // start beats any simultaneous transfer, which is simply dropped
      state     <= S_LOAD;
      ptr       <= BASE_ADDR;
      count     <= '0;
      imem_we   <= 1'b0;
      err       <= 1'b0;
      full      <= 1'b0;
      prog_done <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (xfer) begin
            if (enc_valid) begin
              imem_we    <= 1'b1;
              imem_addr  <= ptr;
              imem_wdata <= word;
              ptr        <= ptr + PTR_ONE;
              count      <= count + CNT_ONE;
              if (last_slot) full <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            if (in_last) begin
`ifdef HALT_APPEND_EN
              // no room left for the halt word: finish immediately
              if (last_slot) begin
                state     <= S_DONE;
                prog_done <= 1'b1;
              end else begin
                state <= S_APPEND;
              end
`else
              state     <= S_DONE;
              prog_done <= 1'b1;
`endif
            end else if (last_slot) begin
              state <= S_FULL;
            end
          end
        end
`ifdef HALT_APPEND_EN
        S_APPEND: begin
          imem_we    <= 1'b1;
          imem_addr  <= ptr;
          imem_wdata <= HALT_WORD;
          ptr        <= ptr + PTR_ONE;
          count      <= count + CNT_ONE;
          if (count == CNT_LAST) full <= 1'b1;
          prog_done  <= 1'b1;
          state      <= S_DONE;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
